// File: rtl/dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lsu_ctrl
//  Description : Load/store sequencer in front of data_memory. It splits
//                misaligned accesses, merges their read data and extends loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [AW+1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rd_dout,
    output logic [AW-1:0]    mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_din,
    output logic [3:0]       mem_wr_strb,
    output logic             mem_we
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WR   = 3'd1;
    localparam logic [2:0] c_ST_RD0  = 3'd2;
    localparam logic [2:0] c_ST_RD1  = 3'd3;
    localparam logic [2:0] c_ST_RESP = 3'd4;

    localparam logic [AW+2:0] c_LAST_BYTE = (AW+3)'(4*DEPTH-1);

    logic [2:0]       r_state;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [1:0]       r_off;
    logic             r_cross;
    logic [WIDTH-1:0] r_rd0;
    logic [AW+1:0]    r_baddr;
    logic [WIDTH-1:0] r_wbytes;
    logic [1:0]       r_left;

    logic [2:0]       w_nbytes;
    logic [2:0]       w_span;
    logic [AW+2:0]    w_end;
    logic             w_aligned;
    logic             w_cross;
    logic             w_err;
    logic [3:0]       w_strb_al;
    logic [WIDTH-1:0] w_din_al;

    always_comb begin
        w_nbytes  = 3'd1;
        w_strb_al = 4'd7;
        w_din_al  = req_wdata;
        case (req_size)
            2'b00: begin
                w_nbytes  = 3'd1;
                w_strb_al = {2'b00, req_addr[1:0]} + 4'd1;
                w_din_al  = {{(WIDTH-8){1'b0}}, req_wdata[7:0]};
            end
            2'b01: begin
                w_nbytes  = 3'd2;
                w_strb_al = req_addr[1] ? 4'd6 : 4'd5;
                w_din_al  = {{(WIDTH-16){1'b0}}, req_wdata[15:0]};
            end
            2'b10: w_nbytes = 3'd4;
            default: w_nbytes = 3'd1;
        endcase
    end

    assign w_aligned = (req_size == 2'b00) ||
                       (req_size == 2'b01 && !req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] == 2'b00);
    assign w_span    = {1'b0, req_addr[1:0]} + (w_nbytes - 3'd1);
    assign w_cross   = (w_span > 3'd3);
    assign w_end     = {1'b0, req_addr} + {{AW{1'b0}}, w_nbytes - 3'd1};
    // Only a misaligned access can run past the last word.
    assign w_err     = (req_size == 2'b11) || (!w_aligned && (w_end > c_LAST_BYTE));

    assign req_ready = (r_state == c_ST_IDLE) && !rst;

    // Little-endian merge of the two fetched words, then sign/zero extension.
    function automatic logic [WIDTH-1:0] f_load(input logic [2*WIDTH-1:0] pair,
                                                input logic [1:0] off,
                                                input logic [1:0] size,
                                                input logic uns);
        logic [WIDTH-1:0] w;
        w = WIDTH'(pair >> {off, 3'b000});
        case (size)
            2'b00:   f_load = {{(WIDTH-8){w[7] & ~uns}}, w[7:0]};
            2'b01:   f_load = {{(WIDTH-16){w[15] & ~uns}}, w[15:0]};
            default: f_load = w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_off       <= '0;
            r_cross     <= 1'b0;
            r_rd0       <= '0;
            r_baddr     <= '0;
            r_wbytes    <= '0;
            r_left      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_addr <= '0;
            mem_wr_din  <= '0;
            mem_wr_strb <= '0;
            mem_we      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_off   <= req_addr[1:0];
                        r_cross <= w_cross;
                        if (w_err) begin
                            r_state   <= c_ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            r_state     <= c_ST_WR;
                            mem_we      <= 1'b1;
                            mem_wr_addr <= req_addr[AW+1:2];
                            if (w_aligned) begin
                                mem_wr_strb <= w_strb_al;
                                mem_wr_din  <= w_din_al;
                                r_left      <= 2'd0;
                            end else begin
                                // Misaligned stores go out one byte per cycle.
                                mem_wr_strb <= {2'b00, req_addr[1:0]} + 4'd1;
                                mem_wr_din  <= {{(WIDTH-8){1'b0}}, req_wdata[7:0]};
                                r_baddr     <= req_addr + (AW+2)'(1);
                                r_wbytes    <= req_wdata >> 8;
                                r_left      <= 2'(w_nbytes - 3'd1);
                            end
                        end else begin
                            r_state     <= c_ST_RD0;
                            mem_rd_addr <= req_addr[AW+1:2];
                        end
                    end
                end
                c_ST_WR: begin
                    if (r_left != 2'd0) begin
                        mem_wr_addr <= r_baddr[AW+1:2];
                        mem_wr_strb <= {2'b00, r_baddr[1:0]} + 4'd1;
                        mem_wr_din  <= {{(WIDTH-8){1'b0}}, r_wbytes[7:0]};
                        r_baddr     <= r_baddr + (AW+2)'(1);
                        r_wbytes    <= r_wbytes >> 8;
                        r_left      <= r_left - 2'd1;
                    end else begin
                        r_state   <= c_ST_RESP;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                c_ST_RD0: begin
                    if (r_cross) begin
                        r_state     <= c_ST_RD1;
                        r_rd0       <= mem_rd_dout;
                        mem_rd_addr <= mem_rd_addr + AW'(1);
                    end else begin
                        r_state   <= c_ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= f_load({{WIDTH{1'b0}}, mem_rd_dout}, r_off, r_size, r_uns);
                    end
                end
                c_ST_RD1: begin
                    r_state   <= c_ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= f_load({mem_rd_dout, r_rd0}, r_off, r_size, r_uns);
                end
                c_ST_RESP: begin
                    r_state   <= c_ST_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_lsu_ctrl
//  Description : Scoreboard bench for dmem_lsu_ctrl with a data_memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_dout;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_din;
    logic [3:0]    mem_wr_strb;
    logic          mem_we;

    logic          mem_clr = 1'b1;
    logic [31:0]   mem [0:DEPTH-1];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [3:0]    s;
        logic [31:0]   d;
    } wr_t;
    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
    } rsp_t;
    wr_t  wq[$];
    rsp_t rq[$];

    dmem_lsu_ctrl #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
        .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
        .mem_wr_strb(mem_wr_strb), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    // data_memory model: asynchronous read, synchronous encoded-strobe write
    assign mem_rd_dout = mem[mem_rd_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            case (mem_wr_strb)
                4'd1: mem[mem_wr_addr][7:0]   <= mem_wr_din[7:0];
                4'd2: mem[mem_wr_addr][15:8]  <= mem_wr_din[7:0];
                4'd3: mem[mem_wr_addr][23:16] <= mem_wr_din[7:0];
                4'd4: mem[mem_wr_addr][31:24] <= mem_wr_din[7:0];
                4'd5: mem[mem_wr_addr][15:0]  <= mem_wr_din[15:0];
                4'd6: mem[mem_wr_addr][31:16] <= mem_wr_din[15:0];
                4'd7: mem[mem_wr_addr]        <= mem_wr_din;
                default: ;
            endcase
        end
    end

    task automatic exp_wr(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d);
        wq.push_back('{a: a, s: s, d: d});
    endtask

    task automatic exp_rsp(input logic [31:0] d, input logic e, input int lat);
        rq.push_back('{d: d, e: e, lat: lat});
    endtask

    // Drives one request, then pops and compares writes and the response as they appear.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] wd, input string name);
        wr_t  ew;
        rsp_t er;
        int   lat;
        bit   done;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = AW'($urandom) << 2; req_wdata = $urandom;
        req_size = 2'($urandom); req_we = 1'($urandom);
        lat = 0; done = 0;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s write: got addr=%0d strb=%0d din=%h want none", name,
                             mem_wr_addr, mem_wr_strb, mem_wr_din);
                end else begin
                    ew = wq.pop_front();
                    if ({mem_wr_addr, mem_wr_strb, mem_wr_din} !== {ew.a, ew.s, ew.d}) begin
                        n_bad++;
                        $display("FAIL %s write: got addr=%0d strb=%0d din=%h want addr=%0d strb=%0d din=%h",
                                 name, mem_wr_addr, mem_wr_strb, mem_wr_din, ew.a, ew.s, ew.d);
                    end
                end
            end
            if (rsp_valid) begin
                done = 1;
                n_cmp++;
                if (rq.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s rsp: got unexpected response", name);
                end else begin
                    er = rq.pop_front();
                    if (rsp_rdata !== er.d || rsp_err !== er.e || lat != er.lat) begin
                        n_bad++;
                        $display("FAIL %s rsp: got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                                 name, rsp_rdata, rsp_err, lat, er.d, er.e, er.lat);
                    end
                end
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: got no rsp_valid want response", name);
            rq.delete();
        end
        n_cmp++;
        if (wq.size() != 0) begin
            n_bad++;
            $display("FAIL %s writes: got %0d missing want 0", name, wq.size());
        end
        wq.delete();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL %s pulse: got rsp_valid=%b mem_we=%b want 0 0", name, rsp_valid, mem_we);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rd_addr, mem_wr_addr,
             mem_wr_din, mem_wr_strb, mem_we} !== '0) begin
            n_bad++;
            $display("FAIL reset outputs: got ready=%b vld=%b rd=%h we=%b strb=%0d want all 0",
                     req_ready, rsp_valid, rsp_rdata, mem_we, mem_wr_strb);
        end
        mem_clr = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word();
        exp_wr(7'd0, 4'd7, 32'h1234_5678); exp_rsp(32'h0, 1'b0, 2);
        issue(1'b1, 2'b10, 1'b0, 9'h000, 32'h1234_5678, "st_word");
        exp_rsp(32'h1234_5678, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b0, 9'h000, 32'h0, "ld_word");
    endtask

    task automatic test_bytes();
        logic [31:0] bytes;
        bytes = 32'hDDCC_BBAA;
        for (int k = 0; k < 4; k++) begin
            exp_wr(7'd1, 4'(k + 1), {24'h0, bytes[8*k +: 8]}); exp_rsp(32'h0, 1'b0, 2);
            issue(1'b1, 2'b00, 1'b0, 9'(4 + k), {24'hEEEEEE, bytes[8*k +: 8]}, "st_byte");
        end
        exp_rsp(32'hDDCC_BBAA, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b0, 9'h004, 32'h0, "ld_word4");
        exp_rsp(32'hFFFF_FFDD, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b0, 9'h007, 32'h0, "ld_byte_s");
        exp_rsp(32'h0000_00DD, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b1, 9'h007, 32'h0, "ld_byte_u");
    endtask

    task automatic test_halves();
        exp_wr(7'd2, 4'd5, 32'h0000_1234); exp_rsp(32'h0, 1'b0, 2);
        issue(1'b1, 2'b01, 1'b0, 9'h008, 32'hFFFF_1234, "st_half_lo");
        exp_wr(7'd2, 4'd6, 32'h0000_5678); exp_rsp(32'h0, 1'b0, 2);
        issue(1'b1, 2'b01, 1'b0, 9'h00A, 32'h0000_5678, "st_half_hi");
        exp_rsp(32'h5678_1234, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b0, 9'h008, 32'h0, "ld_word8");
        exp_rsp(32'h0000_5678, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b0, 9'h00A, 32'h0, "ld_half_s");
    endtask

    task automatic test_misaligned();
        exp_wr(7'd3, 4'd2, 32'hD4); exp_wr(7'd3, 4'd3, 32'hC3);
        exp_wr(7'd3, 4'd4, 32'hB2); exp_wr(7'd4, 4'd1, 32'hA1);
        exp_rsp(32'h0, 1'b0, 5);
        issue(1'b1, 2'b10, 1'b0, 9'h00D, 32'hA1B2_C3D4, "st_mis_word");
        exp_rsp(32'hA1B2_C3D4, 1'b0, 3);
        issue(1'b0, 2'b10, 1'b0, 9'h00D, 32'h0, "ld_mis_word");
        exp_rsp(32'h0000_C3D4, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b1, 9'h00D, 32'h0, "ld_mis_half_in");
        exp_rsp(32'hFFFF_A1B2, 1'b0, 3);
        issue(1'b0, 2'b01, 1'b0, 9'h00F, 32'h0, "ld_mis_half_x");
    endtask

    task automatic test_errors();
        exp_rsp(32'h0, 1'b1, 1);
        issue(1'b1, 2'b01, 1'b0, 9'(4*DEPTH - 1), 32'hBEEF, "err_top_half");
        exp_rsp(32'h0, 1'b1, 1);
        issue(1'b0, 2'b11, 1'b0, 9'h000, 32'h0, "err_size");
        exp_rsp(32'h0, 1'b1, 1);
        issue(1'b0, 2'b10, 1'b0, 9'(4*DEPTH - 2), 32'h0, "err_top_word");
        exp_wr(7'(DEPTH - 1), 4'd4, 32'h5A); exp_rsp(32'h0, 1'b0, 2);
        issue(1'b1, 2'b00, 1'b0, 9'(4*DEPTH - 1), 32'h5A, "st_top_byte");
        exp_rsp(32'h5A00_0000, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b1, 9'(4*DEPTH - 4), 32'h0, "ld_top_word");
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 9'h021; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_wr_addr, mem_wr_strb, mem_wr_din} !== {1'b1, 7'd8, 4'd2, 32'h0D}) begin
            n_bad++;
            $display("FAIL abort first_wr: got we=%b addr=%0d strb=%0d din=%h want 1 8 2 0d",
                     mem_we, mem_wr_addr, mem_wr_strb, mem_wr_din);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rd_addr, mem_wr_addr,
             mem_wr_din, mem_wr_strb, mem_we} !== '0) begin
            n_bad++;
            $display("FAIL abort outputs: got we=%b strb=%0d din=%h vld=%b want all 0",
                     mem_we, mem_wr_strb, mem_wr_din, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort ready: got %b want 1", req_ready);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || mem_we) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL abort quiet: got activity=1 want 0");
        end
        n_cmp++;
        if (mem[8] !== 32'h0000_0D00 || mem[9] !== 32'h0) begin
            n_bad++;
            $display("FAIL abort partial: got w8=%h w9=%h want 00000d00 00000000", mem[8], mem[9]);
        end
        exp_rsp(32'h0000_000D, 1'b0, 3);
        issue(1'b0, 2'b10, 1'b0, 9'h021, 32'h0, "ld_after_abort");
    endtask

    initial begin
        test_reset();
        test_word();
        test_bytes();
        test_halves();
        test_misaligned();
        test_errors();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the single-port-pair data_memory (asynchronous read; synchronous write with encoded 4-bit wr_strb).
- Accepts byte, halfword and word requests at any byte address.
- Converts each request into one or more legal memory operations: splits misaligned accesses and merges their read data.
- Sign/zero-extends loads and returns one response per request.

Parameters:
- WIDTH, 32, data word width (fixed at 32; byte lanes 0..3).
- DEPTH, 128, memory depth in words; AW = $clog2(DEPTH) word-address bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and returns an error.
- req_unsigned  input  1  load zero-extend (1) / sign-extend (0).
- req_addr  input  AW+2  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  valid with rsp_valid.
- mem_rd_addr  output  AW  to data_memory rd_addr0.
- mem_wr_addr  output  AW  to wr_addr0.
- mem_wr_din  output  32  to wr_din0.
- mem_wr_strb  output  4  to wr_strb.
- mem_we  output  1  to we0.

Behaviour:
- Strobe encoding (fixed): 1..4 = byte lanes 0..3; 5 = low half; 6 = high half; 7 = word; 0 = none. Write data is right-aligned in mem_wr_din, upper bits 0.
- Reset values: all outputs 0, state IDLE. req_ready = (state==IDLE), so it is 1 once rst deasserts. rst asserted mid-operation aborts: no further mem_we, no response; the partially written bytes remain.
- States: IDLE, WR, RD0, RD1, RESP.
- Handshake: the request is captured on the edge where req_valid && req_ready; inputs are don't-care otherwise.
- Alignment:
  - Aligned: byte always; half when addr[0]=0; word when addr[1:0]=0.
  - Error: size 11, or a misaligned access whose last byte lies in word DEPTH (crosses the top).
  - On error, go IDLE->RESP directly: no memory op, rsp_err=1, rsp_rdata=0.
- Store, aligned: WR for one cycle with mem_we=1, one encoded op, then RESP.
- Store, misaligned: WR for n cycles (n = size in bytes). Cycle k writes byte k of req_wdata to byte address addr+k, using a byte strobe for lane (addr+k)[1:0] and word (addr+k)>>2. Then RESP.
- Load: RD0 drives mem_rd_addr = addr>>2 and captures rd_dout0 at end of cycle.
  - If the access crosses a word, RD1 drives word+1 and captures it.
  - Merge little-endian: byte k = byte at addr+k.
  - Extend per size/req_unsigned; then RESP.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0; next state IDLE. rsp_rdata/rsp_err hold until the next RESP.
- Latency (accept edge = cycle 0, rsp_valid cycle):
  - aligned store 2; misaligned store n+1.
  - aligned or non-crossing load 2; crossing load 3.
  - error 1.
- mem_we is 0 in every state except WR. mem_rd_addr holds its last value outside RD0/RD1.
- No back-to-back acceptance: the minimum gap between accepts is latency+1 cycles.

Test Plan:
- Aligned word store 0x12345678 @0x00, then word load @0x00 -> one WR cycle with strb=7, wr_addr=0; rsp_rdata=0x12345678, err=0, rsp_valid 2 cycles after each accept.
- Byte stores 0xAA,0xBB,0xCC,0xDD @0x04..0x07 -> strbs 1,2,3,4 on wr_addr=1; word load @0x04 = 0xDDCCBBAA; byte load @0x07 signed = 0xFFFFFFDD, unsigned = 0x000000DD.
- Half stores 0x1234 @0x08, 0x5678 @0x0A -> strb 5 then 6; word load @0x08 = 0x56781234; half load @0x0A signed = 0x00005678.
- Misaligned word store 0xA1B2C3D4 @0x0D -> 4 WR cycles: (word3, strb2, D4), (3, 3, C3), (3, 4, B2), (4, 1, A1); load @0x0D takes RD0+RD1 and returns 0xA1B2C3D4 at latency 3.
- Errors -> rsp_err=1 at latency 1, no mem_we:
  - half store at byte address 4*DEPTH-1;
  - req_size=11.
- rst pulsed during the second WR cycle of a misaligned store -> outputs 0 immediately; rsp_valid never asserts; req_ready=1 after release; next request is serviced normally.
